// File: rtl/type_stage_cfg_loader.sv
// Double-buffered configuration loader for a cascade of 2x2 switching stages.
// Stage words are streamed into a shadow bank one stage at a time. The shadow
// bank is copied to the active bank (switch_set) only on a frame boundary, so
// the datapath never sees a partially updated configuration.
module type_stage_cfg_loader #(
  parameter int SIZE       = 32,
  parameter int SWITCH_NUM = SIZE / 2,
  parameter int STAGES     = 9
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  cfg_valid,
  output logic                                  cfg_ready,
  input  logic [SWITCH_NUM-1:0]                 cfg_word,
  input  logic                                  cfg_abort,
  input  logic                                  frame_start,
  output logic [STAGES-1:0][SWITCH_NUM-1:0]     switch_set,
  output logic                                  cfg_active,
  output logic                                  commit_pulse,
  output logic [$clog2(STAGES+1)-1:0]           load_cnt
);

  localparam int unsigned CNT_W = $clog2(STAGES + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STAGES - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    PENDING
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [STAGES-1:0][SWITCH_NUM-1:0] shadow_q;
  logic                              accept;
  logic                              do_commit;
  logic                              do_clear;

  // Next-state, handshake and commit/clear decisions.
  // rst_n is active-high here; cfg_ready is forced low for the whole reset.
  always_comb begin
    state_d   = state_q;
    cfg_ready = 1'b0;
    accept    = 1'b0;
    do_commit = 1'b0;
    do_clear  = 1'b0;

    cfg_ready = !rst_n && (state_q != PENDING) && !cfg_abort;
    accept    = cfg_valid && cfg_ready;

    case (state_q)
      IDLE: begin
        // Abort in IDLE already blocks acceptance via cfg_ready.
        if (accept) begin
          state_d = (load_cnt == LAST_CNT) ? PENDING : LOAD;
        end
      end
      LOAD: begin
        if (cfg_abort) begin
          state_d  = IDLE;
          do_clear = 1'b1;
        end else if (accept && (load_cnt == LAST_CNT)) begin
          state_d = PENDING;
        end
      end
      PENDING: begin
        // Abort has priority over a coincident frame boundary.
        if (cfg_abort) begin
          state_d  = IDLE;
          do_clear = 1'b1;
        end else if (frame_start) begin
          state_d   = IDLE;
          do_clear  = 1'b1;
          do_commit = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Shadow bank: accepted word lands in the entry selected by load_cnt; never reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int unsigned s = 0; s < STAGES; s++) begin
        if (load_cnt == CNT_W'(s)) begin
          shadow_q[s] <= cfg_word;
        end
      end
    end
  end

  // Control state, word counter and the active bank driving the switches.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q      <= IDLE;
      load_cnt     <= '0;
      commit_pulse <= 1'b0;
      cfg_active   <= 1'b0;
      switch_set   <= '0;
    end else begin
      state_q      <= state_d;
      commit_pulse <= do_commit;
      if (do_clear) begin
        load_cnt <= '0;
      end else if (accept) begin
        load_cnt <= load_cnt + CNT_W'(1);
      end
      if (do_commit) begin
        switch_set <= shadow_q;
        cfg_active <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_type_stage_cfg_loader.sv
// Self-checking bench for type_stage_cfg_loader: directed scenarios with
// literal expectations plus a long randomized run against a queue model.
module tb_type_stage_cfg_loader;

  localparam int SIZE       = 32;
  localparam int SWITCH_NUM = SIZE / 2;
  localparam int STAGES     = 9;
  localparam int CNT_W      = $clog2(STAGES + 1);
  localparam int W          = STAGES * SWITCH_NUM;

  logic                              clk = 1'b0;
  logic                              rst_n = 1'b0;
  logic                              cfg_valid = 1'b0;
  logic                              cfg_ready;
  logic [SWITCH_NUM-1:0]             cfg_word = '0;
  logic                              cfg_abort = 1'b0;
  logic                              frame_start = 1'b0;
  logic [STAGES-1:0][SWITCH_NUM-1:0] switch_set;
  logic                              cfg_active;
  logic                              commit_pulse;
  logic [CNT_W-1:0]                  load_cnt;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Behavioural model: words waiting for commit, the committed configuration,
  // and whether a commit happened on the last edge / ever since reset.
  logic [SWITCH_NUM-1:0] m_q[$];
  logic [SWITCH_NUM-1:0] m_active[STAGES];
  bit                    m_pulse;
  bit                    m_act;
  int                    n_commits = 0;

  type_stage_cfg_loader #(
    .SIZE(SIZE),
    .SWITCH_NUM(SWITCH_NUM),
    .STAGES(STAGES)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_word(cfg_word),
    .cfg_abort(cfg_abort),
    .frame_start(frame_start),
    .switch_set(switch_set),
    .cfg_active(cfg_active),
    .commit_pulse(commit_pulse),
    .load_cnt(load_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    for (int s = 0; s < STAGES; s++) m_active[s] = '0;
    m_pulse = 1'b0;
    m_act   = 1'b0;
  endtask

  // One rising edge worth of behaviour, from the inputs sampled at that edge.
  task automatic model_update();
    m_pulse = 1'b0;
    if (cfg_abort) begin
      m_q.delete();
    end else if (m_q.size() == STAGES && frame_start) begin
      for (int s = 0; s < STAGES; s++) m_active[s] = m_q[s];
      m_q.delete();
      m_pulse = 1'b1;
      m_act   = 1'b1;
      n_commits++;
    end else if (cfg_valid && m_q.size() < STAGES) begin
      m_q.push_back(cfg_word);
    end
  endtask

  task automatic step(input bit v, input logic [SWITCH_NUM-1:0] w, input bit a, input bit f);
    cfg_valid   = v;
    cfg_word    = w;
    cfg_abort   = a;
    frame_start = f;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic load_seq(input int n, input logic [SWITCH_NUM-1:0] w, input bit incr);
    for (int k = 0; k < n; k++) begin
      step(1'b1, incr ? w + SWITCH_NUM'(k) : w, 1'b0, 1'b0);
    end
  endtask

  function automatic logic [W-1:0] all_stages(input logic [SWITCH_NUM-1:0] w);
    logic [STAGES-1:0][SWITCH_NUM-1:0] e;
    for (int s = 0; s < STAGES; s++) e[s] = w;
    return e;
  endfunction

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      logic [STAGES-1:0][SWITCH_NUM-1:0] e;
      bit exp_ready;
      for (int s = 0; s < STAGES; s++) e[s] = m_active[s];
      exp_ready = (rst_n == 1'b0) && (m_q.size() < STAGES) && !cfg_abort;
      chk("cfg_ready", W'(cfg_ready), W'(exp_ready));
      chk("load_cnt", W'(load_cnt), W'(m_q.size()));
      chk("commit_pulse", W'(commit_pulse), W'(m_pulse));
      chk("cfg_active", W'(cfg_active), W'(m_act));
      chk("switch_set", W'(switch_set), W'(e));
    end
  end

  initial begin
    logic [STAGES-1:0][SWITCH_NUM-1:0] e;
    model_reset();
    #1 rst_n = 1'b1;
    #1 cmp_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", W'(cfg_ready), W'(0));
    chk("rst_load_cnt", W'(load_cnt), W'(0));
    chk("rst_switch_set", W'(switch_set), W'(0));
    chk("rst_active", W'(cfg_active), W'(0));
    chk("rst_pulse", W'(commit_pulse), W'(0));
    rst_n = 1'b0;

    // Words 1..9 back-to-back, ready low while pending, then commit.
    load_seq(STAGES, 16'h0001, 1'b1);
    chk("full_load_cnt", W'(load_cnt), W'(9));
    chk("pend_ready0", W'(cfg_ready), W'(0));
    step(1'b0, '0, 1'b0, 1'b0);
    chk("pend_ready1", W'(cfg_ready), W'(0));
    step(1'b0, '0, 1'b0, 1'b0);
    chk("pend_ready2", W'(cfg_ready), W'(0));
    step(1'b0, '0, 1'b0, 1'b1);
    for (int s = 0; s < STAGES; s++) e[s] = SWITCH_NUM'(s + 1);
    chk("commit1_switch", W'(switch_set), W'(e));
    chk("commit1_pulse", W'(commit_pulse), W'(1));
    chk("commit1_active", W'(cfg_active), W'(1));
    chk("commit1_cnt", W'(load_cnt), W'(0));
    step(1'b0, '0, 1'b0, 1'b0);
    chk("pulse_one_cycle", W'(commit_pulse), W'(0));

    // frame_start together with the last word must not commit.
    load_seq(STAGES - 1, 16'h00FF, 1'b0);
    step(1'b1, 16'h00FF, 1'b0, 1'b1);
    chk("lastword_fs_pulse", W'(commit_pulse), W'(0));
    chk("lastword_fs_cnt", W'(load_cnt), W'(9));
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    chk("late_fs_pulse", W'(commit_pulse), W'(1));
    chk("late_fs_switch", W'(switch_set), all_stages(16'h00FF));
    step(1'b0, '0, 1'b0, 1'b0);

    // Abort mid-load keeps the active bank.
    load_seq(4, 16'hAAAA, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("abort_cnt", W'(load_cnt), W'(0));
    chk("abort_switch", W'(switch_set), all_stages(16'h00FF));
    chk("abort_ready", W'(cfg_ready), W'(0));
    step(1'b0, '0, 1'b0, 1'b0);
    chk("post_abort_ready", W'(cfg_ready), W'(1));
    load_seq(STAGES, 16'h5555, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    chk("reload_switch", W'(switch_set), all_stages(16'h5555));
    chk("reload_pulse", W'(commit_pulse), W'(1));

    // Abort and frame_start together while pending: abort wins.
    load_seq(STAGES, 16'h1234, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1);
    chk("abort_fs_pulse", W'(commit_pulse), W'(0));
    chk("abort_fs_switch", W'(switch_set), all_stages(16'h5555));
    chk("abort_fs_cnt", W'(load_cnt), W'(0));
    step(1'b0, '0, 1'b0, 1'b0);
    chk("abort_fs_ready", W'(cfg_ready), W'(1));
    chk("abort_fs_pulse2", W'(commit_pulse), W'(0));

    // Asynchronous reset in the middle of a load.
    load_seq(5, 16'h0F0F, 1'b0);
    #2;
    rst_n = 1'b1;
    model_reset();
    #1;
    chk("async_ready", W'(cfg_ready), W'(0));
    chk("async_cnt", W'(load_cnt), W'(0));
    chk("async_active", W'(cfg_active), W'(0));
    chk("async_pulse", W'(commit_pulse), W'(0));
    chk("async_switch", W'(switch_set), W'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    load_seq(STAGES, 16'h0100, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    for (int s = 0; s < STAGES; s++) e[s] = SWITCH_NUM'(16'h0100 + s);
    chk("post_reset_switch", W'(switch_set), W'(e));
    chk("post_reset_active", W'(cfg_active), W'(1));

    // Randomized traffic with gaps, occasional aborts and frame boundaries.
    n_commits = 0;
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 1) == 1),
           SWITCH_NUM'($urandom),
           ($urandom_range(0, 31) == 0),
           ($urandom_range(0, 5) == 0));
    end
    chk("random_commits_seen", W'(n_commits > 0), W'(1));

    step(1'b0, '0, 1'b0, 1'b0);
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
